// File: rtl/button_debounce.sv
// Push-button debounce: qualifies a stable press, emits one press pulse, requires stable release.
// Optional auto-repeat while held is enabled by defining AUTO_REPEAT_EN.
module button_debounce #(
  parameter int unsigned STABLE_CYCLES  = 50000,
  parameter int unsigned RELEASE_CYCLES = 50000,
  parameter int unsigned CNT_W          = 17,
  parameter int unsigned REPEAT_DELAY   = 25000000,
  parameter int unsigned REPEAT_PERIOD  = 10000000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] button,
  input  logic       debounceEnable,
  output logic       press_valid,
  output logic [1:0] press_code,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, CONFIRM, HELD, RELEASE} state_t;

  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RELEASE_LAST = CNT_W'(RELEASE_CYCLES - 1);

  if (STABLE_CYCLES < 2 || RELEASE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_param_check
    $error("button_debounce: invalid cycle parameters");
  end

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n, cnt_inc;
  logic [1:0]       cand, cand_n, code_n;
  logic             pulse_n;

`ifdef AUTO_REPEAT_EN
  localparam int unsigned REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned REP_W   = $clog2(REP_MAX + 1);

  logic [REP_W-1:0] rep, rep_n, rep_target;
  logic             repeated, repeated_n;

  // First repeat waits the long delay, later ones the shorter period.
  assign rep_target = repeated ? REP_W'(REPEAT_PERIOD - 1) : REP_W'(REPEAT_DELAY - 1);
`endif

  assign cnt_inc = (cnt == '1) ? cnt : cnt + CNT_W'(1);

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    cand_n  = cand;
    pulse_n = 1'b0;
    code_n  = press_code;
`ifdef AUTO_REPEAT_EN
    rep_n      = rep;
    repeated_n = repeated;
`endif
    case (state)
      IDLE: begin
        if (debounceEnable) begin
          cand_n  = button;
          cnt_n   = '0;
          state_n = CONFIRM;
        end
      end
      CONFIRM: begin
        if (debounceEnable && button == cand) begin
          if (cnt == STABLE_LAST) begin
            pulse_n = 1'b1;
            code_n  = cand;
            cnt_n   = '0;
            state_n = HELD;
`ifdef AUTO_REPEAT_EN
            rep_n      = '0;
            repeated_n = 1'b0;
`endif
          end else begin
            cnt_n = cnt_inc;
          end
        end else begin
          cnt_n   = '0;
          state_n = IDLE;
        end
      end
      HELD: begin
        if (!debounceEnable) begin
          cnt_n   = '0;
          state_n = RELEASE;
`ifdef AUTO_REPEAT_EN
          rep_n      = '0;
          repeated_n = 1'b0;
        end else if (rep == rep_target) begin
          pulse_n    = 1'b1;
          code_n     = cand;
          rep_n      = '0;
          repeated_n = 1'b1;
        end else begin
          rep_n = rep + REP_W'(1);
`endif
        end
      end
      RELEASE: begin
        if (debounceEnable) begin
          cnt_n   = '0;
          state_n = HELD;
`ifdef AUTO_REPEAT_EN
          rep_n      = '0;
          repeated_n = 1'b0;
`endif
        end else if (cnt == RELEASE_LAST) begin
          cnt_n   = '0;
          state_n = IDLE;
        end else begin
          cnt_n = cnt_inc;
        end
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      cand        <= '0;
      press_valid <= 1'b0;
      press_code  <= '0;
      busy        <= 1'b0;
`ifdef AUTO_REPEAT_EN
      rep         <= '0;
      repeated    <= 1'b0;
`endif
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      cand        <= cand_n;
      press_valid <= pulse_n;
      press_code  <= code_n;
      busy        <= (state_n != IDLE);
`ifdef AUTO_REPEAT_EN
      rep         <= rep_n;
      repeated    <= repeated_n;
`endif
    end
  end

endmodule

// File: tb/tb_button_debounce.sv
// Bench for button_debounce: fixed vector table, corner-case sequences, random stimulus vs. a run-length model.
// Honours AUTO_REPEAT_EN in the same way as the design.
module tb_button_debounce;

  localparam int S = 4;
  localparam int R = 4;
  localparam int D = 10;
  localparam int P = 5;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] button = 2'b00;
  logic       debounceEnable = 1'b0;
  logic       press_valid;
  logic [1:0] press_code;
  logic       busy;

  button_debounce #(
    .STABLE_CYCLES (S),
    .RELEASE_CYCLES(R),
    .CNT_W         (8),
    .REPEAT_DELAY  (D),
    .REPEAT_PERIOD (P)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .button        (button),
    .debounceEnable(debounceEnable),
    .press_valid   (press_valid),
    .press_code    (press_code),
    .busy          (busy)
  );

  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;
  int pulses   = 0;
  bit prev_pv  = 1'b0;

  // Reference model in terms of run lengths: streak of matching enabled edges
  // while armed, then low/high run lengths while a press is outstanding.
  bit         m_armed = 1'b1;
  int         m_run   = 0;
  int         m_low   = 0;
  int         m_hold  = 0;
  logic [1:0] m_code  = 2'b00;
  logic [1:0] m_pcode = 2'b00;
  bit         m_pv    = 1'b0;

  task automatic model_step(input bit rst, input bit en, input logic [1:0] btn);
    m_pv = 1'b0;
    if (rst) begin
      m_armed = 1'b1; m_run = 0; m_low = 0; m_hold = 0;
      m_code = 2'b00; m_pcode = 2'b00;
    end else if (m_armed) begin
      if (!en) m_run = 0;
      else if (m_run == 0) begin
        m_run = 1; m_code = btn;
      end else if (btn != m_code) m_run = 0;
      else begin
        m_run++;
        if (m_run == S + 1) begin
          m_pv = 1'b1; m_pcode = m_code;
          m_armed = 1'b0; m_run = 0; m_low = 0; m_hold = 0;
        end
      end
    end else if (en) begin
      if (m_low > 0) begin
        m_low = 0; m_hold = 0;
      end else begin
        m_hold++;
`ifdef AUTO_REPEAT_EN
        if (m_hold >= D && (m_hold - D) % P == 0) begin
          m_pv = 1'b1; m_pcode = m_code;
        end
`endif
      end
    end else begin
      m_low++; m_hold = 0;
      if (m_low == R + 1) begin
        m_armed = 1'b1; m_low = 0;
      end
    end
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic apply(input bit rst, input bit en, input logic [1:0] btn, input string tag);
    reset = rst; debounceEnable = en; button = btn;
    @(posedge clock);
    model_step(rst, en, btn);
    #1;
    check({tag, " press_valid"}, int'(press_valid), int'(m_pv));
    check({tag, " press_code"}, int'(press_code), int'(m_pcode));
    check({tag, " busy"}, int'(busy), int'(!(m_armed && m_run == 0)));
    check({tag, " back-to-back pulse"}, int'(prev_pv && press_valid), 0);
    prev_pv = press_valid;
    if (press_valid) pulses++;
  endtask

  task automatic release_all(input string tag);
    for (int i = 0; i < R + 2; i++) apply(1'b0, 1'b0, 2'b00, tag);
  endtask

  typedef struct {
    bit         rst;
    bit         en;
    logic [1:0] btn;
    bit         pv;
    logic [1:0] code;
    bit         busy;
  } vec_t;

  vec_t tbl[12];

  initial begin
    int p0;
    int len;
    bit en;
    logic [1:0] btn;

    tbl[0] = '{1'b1, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0};
    for (int i = 1; i <= 4; i++) tbl[i] = '{1'b0, 1'b1, 2'b10, 1'b0, 2'b00, 1'b1};
    tbl[5] = '{1'b0, 1'b1, 2'b10, 1'b1, 2'b10, 1'b1};
    tbl[6] = '{1'b0, 1'b1, 2'b10, 1'b0, 2'b10, 1'b1};
    for (int i = 7; i <= 10; i++) tbl[i] = '{1'b0, 1'b0, 2'b10, 1'b0, 2'b10, 1'b1};
    tbl[11] = '{1'b0, 1'b0, 2'b10, 1'b0, 2'b10, 1'b0};

    for (int i = 0; i < 12; i++) begin
      apply(tbl[i].rst, tbl[i].en, tbl[i].btn, "table");
      check($sformatf("table[%0d] press_valid", i), int'(press_valid), int'(tbl[i].pv));
      check($sformatf("table[%0d] press_code", i), int'(press_code), int'(tbl[i].code));
      check($sformatf("table[%0d] busy", i), int'(busy), int'(tbl[i].busy));
    end

    // Press bounce: high 2, low 1, high 20 -> one pulse, timed from the restart.
    p0 = pulses;
    apply(1'b0, 1'b1, 2'b01, "pbounce"); apply(1'b0, 1'b1, 2'b01, "pbounce");
    apply(1'b0, 1'b0, 2'b01, "pbounce");
    for (int i = 0; i < 4; i++) apply(1'b0, 1'b1, 2'b01, "pbounce");
    check("pbounce no early pulse", pulses - p0, 0);
    apply(1'b0, 1'b1, 2'b01, "pbounce");
    check("pbounce pulse on 5th edge", int'(press_valid), 1);
    for (int i = 0; i < 15; i++) apply(1'b0, 1'b1, 2'b01, "pbounce");
    check("pbounce pulse count", pulses - p0, 1);
    release_all("pbounce rel");

    // Code glitch: 01 for 2 edges, then 11 -> re-latch and one pulse with code 11.
    p0 = pulses;
    apply(1'b0, 1'b1, 2'b01, "glitch"); apply(1'b0, 1'b1, 2'b01, "glitch");
    for (int i = 0; i < 8; i++) apply(1'b0, 1'b1, 2'b11, "glitch");
    check("glitch pulse count", pulses - p0, 1);
    check("glitch code", int'(press_code), 3);
    release_all("glitch rel");

    // Release bounce: low 2, high 1, low 10 -> no new pulse, busy falls 4 edges after the final low begins.
    for (int i = 0; i < 6; i++) apply(1'b0, 1'b1, 2'b10, "rbounce");
    p0 = pulses;
    apply(1'b0, 1'b0, 2'b10, "rbounce"); apply(1'b0, 1'b0, 2'b10, "rbounce");
    apply(1'b0, 1'b1, 2'b10, "rbounce");
    for (int i = 0; i < 4; i++) apply(1'b0, 1'b0, 2'b10, "rbounce");
    check("rbounce busy before re-arm", int'(busy), 1);
    apply(1'b0, 1'b0, 2'b10, "rbounce");
    check("rbounce busy after re-arm", int'(busy), 0);
    for (int i = 0; i < 5; i++) apply(1'b0, 1'b0, 2'b10, "rbounce");
    check("rbounce no pulse", pulses - p0, 0);

    // Reset mid-CONFIRM, then a full-length press is required.
    for (int i = 0; i < 3; i++) apply(1'b0, 1'b1, 2'b01, "midreset");
    apply(1'b1, 1'b1, 2'b01, "midreset");
    check("midreset press_valid", int'(press_valid), 0);
    check("midreset press_code", int'(press_code), 0);
    check("midreset busy", int'(busy), 0);
    p0 = pulses;
    for (int i = 0; i < 4; i++) apply(1'b0, 1'b1, 2'b01, "midreset");
    check("midreset no early pulse", pulses - p0, 0);
    apply(1'b0, 1'b1, 2'b01, "midreset");
    check("midreset pulse after 5 edges", pulses - p0, 1);
    release_all("midreset rel");

    // Long hold: repeat pulses at accept +10, +15, +20 when auto-repeat is built in.
    p0 = pulses;
    for (int i = 0; i < 26; i++) apply(1'b0, 1'b1, 2'b00, "hold");
`ifdef AUTO_REPEAT_EN
    check("hold pulse count", pulses - p0, 4);
`else
    check("hold pulse count", pulses - p0, 1);
`endif
    release_all("hold rel");

    // Random bursts with occasional code changes and rare resets.
    for (int n = 0; n < 400; n++) begin
      en  = 1'($urandom_range(0, 1));
      len = ($urandom_range(0, 7) == 0) ? int'($urandom_range(10, 30)) : int'($urandom_range(1, 8));
      btn = 2'($urandom_range(0, 3));
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 9) == 0) btn = 2'($urandom_range(0, 3));
        apply(($urandom_range(0, 149) == 0), en, btn, "random");
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
